seq_alu_ctrl: RTL and testbench

Parametrised, handshaked successor to the team's 32-bit ALU/Booth pair. Executes eight operations on N-bit operands.
- Single-cycle ops: add, sub, shifts, logic.
- Multi-cycle ops: iterative radix-2 Booth signed multiply (full 2N product) and restoring unsigned divide (quotient plus remainder).
- Fixes the old multiplier's missing reset, one-shot start and width mismatch.
- Sits between the datapath issue logic and writeback, using valid/ready on both sides.

---
 rtl/seq_alu_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_seq_alu_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_ctrl.sv
// rtl/seq_alu_ctrl.sv - handshaked ALU with iterative Booth multiply and restoring divide
module seq_alu_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res_lo,
    output logic [N-1:0] res_hi,
    output logic         carry_out,
    output logic         div_zero
);
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_AND = 3'd6;
    localparam logic [2:0] OP_OR  = 3'd7;

    localparam logic [N-1:0]  N_LIM   = N'(N);
    localparam logic [CW-1:0] CNT_INI = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]    state;
    logic [N:0]    acc;
    logic [N:0]    mcand;
    logic [N-1:0]  qb;
    logic          qm1;
    logic [N-1:0]  rem;
    logic [N-1:0]  divisor;
    logic [CW-1:0] cnt;

    logic [N:0]    add_full;
    logic [N:0]    sub_full;
    logic          shift_ok;
    logic [N-1:0]  shl_res;
    logic [N-1:0]  shr_res;
    logic [N:0]    booth_sum;
    logic [N:0]    booth_acc_nx;
    logic [N-1:0]  booth_q_nx;
    logic [N:0]    rem_sh;
    logic          div_ge;
    logic [N-1:0]  rem_sub;
    logic [N-1:0]  rem_nx;
    logic [N-1:0]  quo_nx;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} - {1'b0, b};

    // Any shift amount of N or more clears the whole word.
    assign shift_ok = (b < N_LIM);
    assign shl_res  = shift_ok ? (a << b[CW-1:0]) : '0;
    assign shr_res  = shift_ok ? (a >> b[CW-1:0]) : '0;

    always_comb begin
        booth_sum = acc;
        case ({qb[0], qm1})
            2'b10:   booth_sum = acc - mcand;
            2'b01:   booth_sum = acc + mcand;
            default: booth_sum = acc;
        endcase
    end

    assign booth_acc_nx = {booth_sum[N], booth_sum[N:1]};
    assign booth_q_nx   = {booth_sum[0], qb[N-1:1]};

    // qb holds the quotient bits while dividing; rem stays below the divisor.
    assign rem_sh  = {rem, qb[N-1]};
    assign div_ge  = (rem_sh >= {1'b0, divisor});
    assign rem_sub = rem_sh[N-1:0] - divisor;
    assign rem_nx  = div_ge ? rem_sub : rem_sh[N-1:0];
    assign quo_nx  = {qb[N-2:0], div_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            mcand     <= '0;
            qb        <= '0;
            qm1       <= 1'b0;
            rem       <= '0;
            divisor   <= '0;
            cnt       <= '0;
            res_lo    <= '0;
            res_hi    <= '0;
            carry_out <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        res_hi    <= '0;
                        carry_out <= 1'b0;
                        div_zero  <= 1'b0;
                        state     <= S_DONE;
                        case (op)
                            OP_ADD: begin
                                res_lo    <= add_full[N-1:0];
                                carry_out <= add_full[N];
                            end
                            OP_SUB: begin
                                res_lo    <= sub_full[N-1:0];
                                carry_out <= sub_full[N];
                            end
                            OP_MUL: begin
                                acc   <= '0;
                                mcand <= {a[N-1], a};
                                qb    <= b;
                                qm1   <= 1'b0;
                                cnt   <= CNT_INI;
                                state <= S_MUL;
                            end
                            OP_DIV: begin
                                if (b == '0) begin
                                    res_lo   <= '1;
                                    res_hi   <= a;
                                    div_zero <= 1'b1;
                                end else begin
                                    rem     <= '0;
                                    qb      <= a;
                                    divisor <= b;
                                    cnt     <= CNT_INI;
                                    state   <= S_DIV;
                                end
                            end
                            OP_SHL: res_lo <= shl_res;
                            OP_SHR: res_lo <= shr_res;
                            OP_AND: res_lo <= a & b;
                            OP_OR:  res_lo <= a | b;
                            default: res_lo <= '0;
                        endcase
                    end
                end
                S_MUL: begin
                    acc <= booth_acc_nx;
                    qb  <= booth_q_nx;
                    qm1 <= qb[0];
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        res_hi <= booth_acc_nx[N-1:0];
                        res_lo <= booth_q_nx;
                        state  <= S_DONE;
                    end
                end
                S_DIV: begin
                    rem <= rem_nx;
                    qb  <= quo_nx;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        res_lo <= quo_nx;
                        res_hi <= rem_nx;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu_ctrl.sv
// tb/tb_seq_alu_ctrl.sv - randomized and directed self-checking bench for seq_alu_ctrl
module tb_seq_alu_ctrl;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] res_lo;
    logic [N-1:0] res_hi;
    logic         carry_out;
    logic         div_zero;

    int checks = 0;
    int failures = 0;

    bit           mon_en = 1'b0;
    bit           zero_chk = 1'b1;
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    int           m_cd = 0;
    logic [N-1:0] e_lo, e_hi;
    logic         e_c, e_dz;

    seq_alu_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .res_lo(res_lo), .res_hi(res_hi), .carry_out(carry_out), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                                  output logic [N-1:0] lo, output logic [N-1:0] hi,
                                  output logic c, output logic dz);
        logic [N:0]     w;
        logic [2*N-1:0] p;
        lo = '0; hi = '0; c = 1'b0; dz = 1'b0;
        case (o)
            3'd0: begin w = {1'b0, x} + {1'b0, y}; lo = w[N-1:0]; c = w[N]; end
            3'd1: begin lo = x - y; c = (x < y); end
            3'd2: begin
                p = {{N{x[N-1]}}, x} * {{N{y[N-1]}}, y};
                lo = p[N-1:0];
                hi = p[2*N-1:N];
            end
            3'd3: begin
                if (y == 0) begin lo = '1; hi = x; dz = 1'b1; end
                else begin lo = x / y; hi = x % y; end
            end
            3'd4: lo = (y >= N) ? '0 : (x << y);
            3'd5: lo = (y >= N) ? '0 : (x >> y);
            3'd6: lo = x & y;
            default: lo = x | y;
        endcase
    endfunction

    // Per-cycle comparison against the reference model, evaluated between edges.
    always @(negedge clk) begin
        if (mon_en) begin
            if (zero_chk) begin
                chk("rst_res_lo", res_lo, 0);
                chk("rst_res_hi", res_hi, 0);
                chk("rst_flags", {carry_out, div_zero}, 0);
                zero_chk = 1'b0;
            end
            chk("in_ready", in_ready, !m_busy && !m_done);
            chk("out_valid", out_valid, m_done);
            if (m_done && out_valid) begin
                chk("res_lo", res_lo, e_lo);
                chk("res_hi", res_hi, e_hi);
                chk("carry_out", carry_out, e_c);
                chk("div_zero", div_zero, e_dz);
            end
            if (rst) begin
                m_busy = 1'b0; m_done = 1'b0; zero_chk = 1'b1;
            end else if (m_done) begin
                if (out_ready) m_done = 1'b0;
            end else if (m_busy) begin
                m_cd--;
                if (m_cd == 0) begin m_busy = 1'b0; m_done = 1'b1; end
            end else if (in_valid) begin
                model(op, a, b, e_lo, e_hi, e_c, e_dz);
                if (op == 3'd2 || (op == 3'd3 && b != 0)) begin
                    m_busy = 1'b1; m_cd = N;
                end else begin
                    m_done = 1'b1;
                end
            end
        end
    end

    task automatic wait_accept(input string nm, output bit ok);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin t++; @(negedge clk); end
        ok = in_ready;
        if (!ok) chk({nm, "_accept_timeout"}, 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom);
    endtask

    task automatic do_op(input string nm, input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [N-1:0] xlo, input logic [N-1:0] xhi, input logic xc, input logic xdz,
                         input int xlat);
        logic [N-1:0] mlo, mhi;
        logic mc, mdz;
        bit ok;
        int lat;
        model(o, x, y, mlo, mhi, mc, mdz);
        chk({nm, "_model"}, {mhi, mlo}, {xhi, xlo});
        chk({nm, "_model_flags"}, {mc, mdz}, {xc, xdz});
        @(posedge clk); #1;
        op = o; a = x; b = y; in_valid = 1'b1;
        wait_accept(nm, ok);
        if (ok) begin
            lat = 1;
            @(negedge clk);
            while (!out_valid && lat < 200) begin lat++; @(negedge clk); end
            chk({nm, "_latency"}, lat, xlat);
            chk({nm, "_res"}, {res_hi, res_lo}, {xhi, xlo});
            chk({nm, "_flags"}, {carry_out, div_zero}, {xc, xdz});
        end
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return N'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit ok;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        do_op("add_carry", 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 1'b1, 1'b0, 1);
        do_op("mul_neg3x7", 3'd2, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b0, N + 1);
        do_op("mul_minsq", 3'd2, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 1'b0, 1'b0, N + 1);
        do_op("div_100_7", 3'd3, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, N + 1);
        do_op("div_zero", 3'd3, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, 1);

        // Backpressure: result must hold while junk is presented on the input side.
        @(posedge clk); #1;
        out_ready = 1'b0;
        do_op("sub_borrow", 3'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom); a = $urandom; b = $urandom; op = 3'($urandom);
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_res_lo", res_lo, 32'hFFFF_FFFE);
            chk("bp_carry", carry_out, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;

        // Reset in the middle of a multiply: that operation never completes.
        @(posedge clk); #1;
        op = 3'd2; a = 32'd12345; b = 32'd678; in_valid = 1'b1;
        wait_accept("abort_mul", ok);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", seen, 0);

        do_op("shl_31", 3'd4, 32'd1, 32'd31, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1);
        do_op("shl_32", 3'd4, 32'd1, 32'd32, 32'h0, 32'h0, 1'b0, 1'b0, 1);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 299) == 0);
            in_valid = 1'($urandom);
            op = 3'($urandom);
            a = pick();
            b = (op == 3'd4 || op == 3'd5) ? N'($urandom_range(0, 40)) : pick();
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
